// File: rtl/ha_bist_ctrl.sv
// ha_bist_ctrl: built-in self-test controller for a half adder.
// Sweeps the four a/b input patterns LOOPS times. Each pattern is held for
// SETTLE_CYCLES before sum/carry are compared against a^b / a&b. The run ends
// with a one-cycle done pulse, a pass flag, a saturating mismatch count and a
// per-pattern sticky fail vector.
// Optional feature: define HA_BIST_STOP_ON_FAIL_EN to end the run at the
// first mismatch. a/b then keep the failing pattern for debug.
module ha_bist_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int LOOPS         = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             sum,
    input  logic             carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [7:0]       LOOP_LAST = 8'(LOOPS - 1);
    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    // Returns 1 when the half-adder response disagrees with the golden result.
    function automatic logic ha_mismatch(input logic in_a, input logic in_b,
                                         input logic rsp_sum, input logic rsp_carry);
        logic [1:0] exp_v;
        exp_v = {in_a ^ in_b, in_a & in_b};
        return ({rsp_sum, rsp_carry} != exp_v);
    endfunction

    state_t           state_r, state_next_s;
    logic [1:0]       idx_r, idx_next_s;
    logic [7:0]       loop_r, loop_next_s;
    logic [3:0]       settle_r, settle_next_s;
    logic             a_r, a_next_s;
    logic             b_r, b_next_s;
    logic             busy_r, busy_next_s;
    logic             done_r, done_next_s;
    logic             pass_r, pass_next_s;
    logic [ERR_W-1:0] err_r, err_next_s;
    logic [3:0]       fv_r, fv_next_s;
    logic             mismatch_s;
    logic             stop_s;

    assign a         = a_r;
    assign b         = b_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_count = err_r;
    assign fail_vec  = fv_r;

    // Compare the response against the pattern currently held on a/b.
    always_comb begin
        mismatch_s = ha_mismatch(a_r, b_r, sum, carry);
`ifdef HA_BIST_STOP_ON_FAIL_EN
        stop_s = mismatch_s;
`else
        stop_s = 1'b0;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and next-value logic for the whole controller.
    always_comb begin
        state_next_s  = state_r;
        idx_next_s    = idx_r;
        loop_next_s   = loop_r;
        settle_next_s = settle_r;
        a_next_s      = a_r;
        b_next_s      = b_r;
        pass_next_s   = pass_r;
        err_next_s    = err_r;
        fv_next_s     = fv_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    err_next_s   = {ERR_W{1'b0}};
                    fv_next_s    = 4'b0000;
                    pass_next_s  = 1'b0;
                    idx_next_s   = 2'd0;
                    loop_next_s  = 8'd0;
                    state_next_s = ST_DRIVE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                a_next_s      = idx_r[1];
                b_next_s      = idx_r[0];
                settle_next_s = SETTLE_LD;
                state_next_s  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_r <= 4'd1) begin
                    settle_next_s = 4'd0;
                    state_next_s  = ST_CHECK;
                end else begin
                    settle_next_s = settle_r - 4'd1;
                end
            end
            ST_CHECK: begin
                if (mismatch_s) begin
                    if (err_r != ERR_MAX) begin
                        err_next_s = err_r + ERR_W'(1);
                    end else begin
                        err_next_s = err_r;
                    end
                    fv_next_s[idx_r] = 1'b1;
                end else begin
                    err_next_s = err_r;
                end
                if (stop_s || (idx_r == 2'd3 && loop_r == LOOP_LAST)) begin
                    pass_next_s  = (err_next_s == {ERR_W{1'b0}});
                    state_next_s = ST_DONE;
                end else if (idx_r == 2'd3) begin
                    idx_next_s   = 2'd0;
                    loop_next_s  = loop_r + 8'd1;
                    state_next_s = ST_DRIVE;
                end else begin
                    idx_next_s   = idx_r + 2'd1;
                    state_next_s = ST_DRIVE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        busy_next_s = (state_next_s != ST_IDLE);
        done_next_s = (state_next_s == ST_DONE);
    end

    // Datapath and status registers; busy/done track the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r    <= 2'd0;
            loop_r   <= 8'd0;
            settle_r <= 4'd0;
            a_r      <= 1'b0;
            b_r      <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
            err_r    <= {ERR_W{1'b0}};
            fv_r     <= 4'b0000;
        end else begin
            idx_r    <= idx_next_s;
            loop_r   <= loop_next_s;
            settle_r <= settle_next_s;
            a_r      <= a_next_s;
            b_r      <= b_next_s;
            busy_r   <= busy_next_s;
            done_r   <= done_next_s;
            pass_r   <= pass_next_s;
            err_r    <= err_next_s;
            fv_r     <= fv_next_s;
        end
    end

endmodule

// File: doc/ha_bist_ctrl.md
Name: ha_bist_ctrl

Overview:
- Sequential stimulus-generator and response-checker for the half-adder datapath. It is the driving and checking end of the a/b/sum/carry interface.
- It sweeps all four input patterns, waits for settling, compares sum/carry against the expected a^b / a&b, and reports pass/fail.
- Sits beside a half-adder instance for power-on self-test and for synthesizable in-system checking.

Parameters:
- SETTLE_CYCLES, 1, cycles to wait after driving a/b before sampling sum/carry; legal range 1..15.
- LOOPS, 1, number of full 4-pattern sweeps per run; legal range 1..255.
- ERR_W, 8, width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle run request; honoured only in IDLE.
- a  output  1  stimulus to the half adder, registered.
- b  output  1  stimulus to the half adder, registered.
- sum  input  1  half-adder sum response.
- carry  input  1  half-adder carry response.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  high when the last run had zero mismatches; held until the next start.
- err_count  output  ERR_W  mismatches in the current/last run; saturates at all-ones.
- fail_vec  output  4  sticky bit per pattern index (0..3) that mismatched at least once in the run.

Behaviour:
- Reset, asynchronous and active-high: state=IDLE; a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0; pattern index, loop counter and settle counter all 0.
- Pattern order, index 0..3: a=idx[1], b=idx[0], giving 00, 01, 10, 11.
- Expected values: sum_exp = a^b, carry_exp = a&b, computed from the registered a/b.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE: if start=1, clear err_count, fail_vec, pass, idx and loop counter; go to DRIVE. Otherwise stay; a/b hold their last values.
- DRIVE: register a/b from idx, load settle counter with SETTLE_CYCLES, go to SETTLE.
- SETTLE: decrement counter each cycle; when it reaches 0, go to CHECK. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- CHECK: sample sum/carry.
  - On mismatch in either bit: err_count += 1, saturating; set fail_vec[idx].
  - Then, if idx=3 and loop = LOOPS-1, go to DONE.
  - Else if idx=3: idx=0, loop+=1, go to DRIVE.
  - Else: idx+=1, go to DRIVE.
- DONE: done=1 for this single cycle; pass = (err_count==0, including any update made in the final CHECK); go to IDLE.
- Cycles per pattern: SETTLE_CYCLES+2. Run length from start-accept edge to done pulse: 4*LOOPS*(SETTLE_CYCLES+2)+1 cycles.
- busy is high in DRIVE, SETTLE, CHECK and DONE.
- start while busy is ignored; there is no restart mid-run.
- start and done in the same cycle: the FSM is in DONE, so start is ignored.
- rst mid-run aborts immediately to the reset values; no done pulse is generated.
- err_count saturates and never wraps. fail_vec bits are sticky for the whole run, including across loops.

Optional Feature:
- Macro: HA_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK transitions directly to DONE.
  - err_count ends at 1 and fail_vec has exactly one bit set.
  - pass=0.
  - a/b hold the failing pattern until the next start, for debug.
- Undefined: the run always completes all 4*LOOPS patterns as described above.

Test Plan:
- Good half adder (sum=a^b, carry=a&b), SETTLE_CYCLES=1, LOOPS=1, pulse start -> a/b step 00, 01, 10, 11 every 3 cycles; done pulses 13 cycles after the start-accept edge; pass=1, err_count=0, fail_vec=0000.
- Faulty adder with carry stuck-at-0, LOOPS=2 -> pass=0, err_count=2, fail_vec=1000; done pulses after 25 cycles.
- Faulty adder with sum stuck-at-1 -> mismatches at patterns 00 and 11; err_count=2, fail_vec=1001, pass=0.
- Assert rst during SETTLE of pattern 2, then release -> all outputs at their reset values, no done pulse. A new start then gives a full clean run with pass=1.
- start pulsed again while busy, plus start held high through DONE -> neither restarts the run. Exactly one done pulse; a new run begins only on a start seen in IDLE.
- With HA_BIST_STOP_ON_FAIL_EN, carry stuck-at-0 -> done pulses after CHECK of pattern 3 (13 cycles); a=1, b=1 held; err_count=1, fail_vec=1000.
